// File: rtl/ro_reg_pkg.sv
// Shared constants for the read-only status register bank: per-channel update modes.
// Latency: n/a (constants only).
// Backpressure: n/a.
package ro_reg_pkg;

  localparam int RO_MODE_W = 2;

  localparam logic [RO_MODE_W-1:0] RO_MODE_LIVE    = 2'd0;
  localparam logic [RO_MODE_W-1:0] RO_MODE_CAPTURE = 2'd1;
  localparam logic [RO_MODE_W-1:0] RO_MODE_STICKY  = 2'd2;
  localparam logic [RO_MODE_W-1:0] RO_MODE_MAXW    = 2'd3;

endpackage

// File: rtl/ro_reg_chan.sv
// One status channel register with compile-time update mode (live/capture/sticky/high-watermark).
// Latency: value reflects data_in/cap_stb/clr one clk edge later.
// Backpressure: none; updates every cycle, clr is honoured only by sticky and watermark modes.
module ro_reg_chan
  import ro_reg_pkg::*;
#(
  parameter int                    DATA_W        = 32,
  parameter logic [RO_MODE_W-1:0]  MODE          = RO_MODE_LIVE,
  parameter logic [DATA_W-1:0]     DEFAULT_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              cap_stb,
  input  logic              clr,
  output logic [DATA_W-1:0] value
);

  logic [DATA_W-1:0] nxt;

  // Select the next register value for this channel's mode; a clear reloads
  // from data_in so bits/peaks arriving in the clearing cycle are kept.
  always_comb begin
    nxt = value;
    case (MODE)
      RO_MODE_LIVE:    nxt = data_in;
      RO_MODE_CAPTURE: nxt = cap_stb ? data_in : value;
      RO_MODE_STICKY:  nxt = clr ? data_in : (value | data_in);
      RO_MODE_MAXW:    nxt = (clr || (data_in > value)) ? data_in : value;
      default:         nxt = value;
    endcase
  end

  // Channel register; reset wins over any update or clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      value <= DEFAULT_VALUE;
    end else begin
      value <= nxt;
    end
  end

endmodule

// File: rtl/ro_reg_bank.sv
// Bank of CH_NUM read-only status registers with a registered req/ack read port; optional snapshot
// view when RO_REG_BANK_SNAPSHOT_EN is defined. Latency: rd_ack/rd_data/rd_err one cycle after rd_req.
// Backpressure: none; a read is accepted every cycle, back-to-back reads allowed.
module ro_reg_bank
  import ro_reg_pkg::*;
#(
  parameter int                          DATA_W        = 32,
  parameter int                          CH_NUM        = 4,
  parameter int                          ADDR_W        = 2,
  parameter logic [DATA_W-1:0]           DEFAULT_VALUE = '0,
  parameter logic [RO_MODE_W*CH_NUM-1:0] MODE_VEC      = '0
) (
  input  logic                     clk_reg,
  input  logic                     rst_reg,
  input  logic [CH_NUM*DATA_W-1:0] data_in,
  input  logic [CH_NUM-1:0]        cap_stb,
  input  logic                     rd_req,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic                     rd_ack,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_err,
  output logic [CH_NUM*DATA_W-1:0] data_out
);

  // One extra bit so CH_NUM itself is representable when 2^ADDR_W == CH_NUM.
  localparam logic [ADDR_W:0] CH_LIMIT = (ADDR_W+1)'(CH_NUM);

  logic [DATA_W-1:0] regs [CH_NUM];
  logic [CH_NUM-1:0] addr_hit;
  logic [CH_NUM-1:0] clr;
  logic              in_range;
  logic              addr_zero;
  logic [DATA_W-1:0] rd_mux;

  assign in_range  = {1'b0, rd_addr} < CH_LIMIT;
  assign addr_zero = (rd_addr == '0);

`ifdef RO_REG_BANK_SNAPSHOT_EN
  logic [DATA_W-1:0] shadow [CH_NUM];
`endif

  for (genvar i = 0; i < CH_NUM; i++) begin : g_chan
    assign addr_hit[i] = ({1'b0, rd_addr} == (ADDR_W+1)'(i));

`ifdef RO_REG_BANK_SNAPSHOT_EN
    // Every channel clears when the snapshot is taken, not on its own read.
    assign clr[i] = rd_req & addr_zero;
`else
    assign clr[i] = rd_req & addr_hit[i];
`endif

    ro_reg_chan #(
      .DATA_W        (DATA_W),
      .MODE          (MODE_VEC[RO_MODE_W*i +: RO_MODE_W]),
      .DEFAULT_VALUE (DEFAULT_VALUE)
    ) u_chan (
      .clk     (clk_reg),
      .rst     (rst_reg),
      .data_in (data_in[i*DATA_W +: DATA_W]),
      .cap_stb (cap_stb[i]),
      .clr     (clr[i]),
      .value   (regs[i])
    );

    assign data_out[i*DATA_W +: DATA_W] = regs[i];
  end

  // Pick the addressed value (pre-update); address 0 always reads the live register.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (addr_hit[i]) begin
`ifdef RO_REG_BANK_SNAPSHOT_EN
        rd_mux = (i == 0) ? regs[i] : shadow[i];
`else
        rd_mux = regs[i];
`endif
      end
    end
  end

`ifdef RO_REG_BANK_SNAPSHOT_EN
  // Snapshot every channel at the address-0 read for an atomic multi-channel view.
  always_ff @(posedge clk_reg) begin
    if (rst_reg) begin
      for (int i = 0; i < CH_NUM; i++) shadow[i] <= DEFAULT_VALUE;
    end else if (rd_req && addr_zero) begin
      for (int i = 0; i < CH_NUM; i++) shadow[i] <= regs[i];
    end
  end
`else
  // addr_zero only matters for snapshots; keep it referenced in the plain build.
  logic unused_addr_zero;
  assign unused_addr_zero = addr_zero;
`endif

  // Registered read response; data/err hold until the next accepted read.
  always_ff @(posedge clk_reg) begin
    if (rst_reg) begin
      rd_ack  <= 1'b0;
      rd_data <= '0;
      rd_err  <= 1'b0;
    end else begin
      rd_ack <= rd_req;
      if (rd_req) begin
        rd_data <= in_range ? rd_mux : '0;
        rd_err  <= ~in_range;
      end
    end
  end

endmodule

// File: tb/tb_ro_reg_bank.sv
// Self-checking bench for ro_reg_bank: directed vector table plus randomized run against a model.
// Latency: checks outputs 1 ns after each rising edge.
// Backpressure: n/a.
module tb_ro_reg_bank;

  localparam int          DW  = 32;
  localparam int          NCH = 4;
  localparam logic [31:0] DEF = 32'hA5A5_0000;
  // ch0 CAPTURE, ch1 STICKY, ch2 MAXW, ch3 LIVE
  localparam logic [7:0]  MODES = 8'b00_11_10_01;
`ifdef RO_REG_BANK_SNAPSHOT_EN
  localparam bit SNAP = 1'b1;
`else
  localparam bit SNAP = 1'b0;
`endif

  logic                  clk_reg = 1'b0;
  logic                  rst_reg;
  logic [NCH-1:0][DW-1:0] din;
  logic [NCH-1:0]        cap_stb;
  logic                  rd_req;
  logic [2:0]            rd_addr;
  logic                  rd_ack;
  logic [DW-1:0]         rd_data;
  logic                  rd_err;
  logic [NCH*DW-1:0]     data_out;

  int checks = 0;
  int errors = 0;

  always #5 clk_reg = ~clk_reg;

  ro_reg_bank #(
    .DATA_W(DW), .CH_NUM(NCH), .ADDR_W(3), .DEFAULT_VALUE(DEF), .MODE_VEC(MODES)
  ) dut (
    .clk_reg  (clk_reg),
    .rst_reg  (rst_reg),
    .data_in  (din),
    .cap_stb  (cap_stb),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .rd_ack   (rd_ack),
    .rd_data  (rd_data),
    .rd_err   (rd_err),
    .data_out (data_out)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_reg);
    #1;
  endtask

  typedef struct packed {
    logic                   req;
    logic [2:0]             addr;
    logic [3:0]             stb;
    logic [3:0][31:0]       d;
    logic                   ack;
    logic [31:0]            rdata;
    logic                   err;
    logic [3:0][31:0]       q;
  } vec_t;

  function automatic vec_t mk(input logic req, input logic [2:0] addr, input logic [3:0] stb,
                              input logic [31:0] d3, d2, d1, d0,
                              input logic ack, input logic [31:0] rdata, input logic err,
                              input logic [31:0] q3, q2, q1, q0);
    vec_t v;
    v.req = req; v.addr = addr; v.stb = stb;
    v.d = {d3, d2, d1, d0};
    v.ack = ack; v.rdata = rdata; v.err = err;
    v.q = {q3, q2, q1, q0};
    return v;
  endfunction

  // Reference model state (spec-level: array of channel values, shadows, read response)
  logic [31:0] m_reg [NCH];
  logic [31:0] m_shd [NCH];
  logic        m_ack;
  logic [31:0] m_data;
  logic        m_err;
  int          mode_of [NCH] = '{1, 2, 3, 0};

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_reg[i] = DEF;
      m_shd[i] = DEF;
    end
    m_ack = 0; m_data = 0; m_err = 0;
  endtask

  task automatic model_step();
    logic [31:0] pre [NCH];
    int a;
    bit clear;
    if (rst_reg) begin
      model_reset();
      return;
    end
    a = int'(rd_addr);
    for (int i = 0; i < NCH; i++) pre[i] = m_reg[i];
    m_ack = rd_req;
    if (rd_req) begin
      if (a >= NCH) begin
        m_data = 0; m_err = 1;
      end else begin
        m_err  = 0;
        m_data = (SNAP && a != 0) ? m_shd[a] : pre[a];
      end
    end
    for (int i = 0; i < NCH; i++) begin
      clear = rd_req && (SNAP ? (a == 0) : (a == i));
      case (mode_of[i])
        0: m_reg[i] = din[i];
        1: m_reg[i] = cap_stb[i] ? din[i] : pre[i];
        2: m_reg[i] = clear ? din[i] : (pre[i] | din[i]);
        default: m_reg[i] = clear ? din[i] : ((din[i] > pre[i]) ? din[i] : pre[i]);
      endcase
    end
    if (SNAP && rd_req && a == 0) begin
      for (int i = 0; i < NCH; i++) m_shd[i] = pre[i];
    end
  endtask

  vec_t tab [10];
  int   ntab;

  initial begin
    rst_reg = 1; rd_req = 0; rd_addr = 0; cap_stb = 0; din = '0;

    // Reset state
    tick(); tick();
    chk("reset_ack", {31'd0, rd_ack}, 32'd0);
    chk("reset_data", rd_data, 32'd0);
    chk("reset_err", {31'd0, rd_err}, 32'd0);
    for (int i = 0; i < NCH; i++) chk($sformatf("reset_ch%0d", i), data_out[i*DW +: DW], DEF);

    // Read accepted while reset is asserted gives no ack
    rd_req = 1; rd_addr = 3'd1; din = {32'h1, 32'h2, 32'h3, 32'h4}; cap_stb = 4'hF;
    tick();
    chk("rst_req_ack", {31'd0, rd_ack}, 32'd0);
    chk("rst_req_data", rd_data, 32'd0);
    chk("rst_req_ch3", data_out[3*DW +: DW], DEF);

    rst_reg = 0;
`ifdef RO_REG_BANK_SNAPSHOT_EN
    ntab = 6;
    tab[0] = mk(0, 0, 0, 32'h77, 0, 0, 0, 0, 0, 0, 32'h77, DEF, DEF, DEF);
    tab[1] = mk(1, 0, 0, 32'h88, 0, 0, 0, 1, DEF, 0, 32'h88, 0, 0, DEF);
    tab[2] = mk(0, 0, 0, 32'h99, 5, 0, 0, 0, DEF, 0, 32'h99, 5, 0, DEF);
    tab[3] = mk(1, 3, 0, 32'hAA, 0, 1, 0, 1, 32'h77, 0, 32'hAA, 5, 1, DEF);
    tab[4] = mk(1, 1, 0, 32'hBB, 0, 2, 0, 1, DEF, 0, 32'hBB, 5, 3, DEF);
    tab[5] = mk(1, 4, 0, 32'hCC, 0, 0, 0, 1, 0, 1, 32'hCC, 5, 3, DEF);
`else
    ntab = 10;
    tab[0] = mk(1, 1, 0, 32'h30, 32'hFFFF, 0, 32'h1111, 1, DEF, 0, 32'h30, DEF, 0, DEF);
    tab[1] = mk(1, 2, 0, 32'h31, 0, 0, 32'h1111, 1, DEF, 0, 32'h31, 0, 0, DEF);
    tab[2] = mk(0, 0, 1, 32'h32, 7, 1, 32'hDEAD, 0, DEF, 0, 32'h32, 7, 1, 32'hDEAD);
    tab[3] = mk(0, 0, 0, 32'h33, 3, 4, 32'h1234, 0, DEF, 0, 32'h33, 7, 5, 32'hDEAD);
    tab[4] = mk(1, 1, 0, 32'h34, 9, 32'h10, 32'h5555, 1, 5, 0, 32'h34, 9, 32'h10, 32'hDEAD);
    tab[5] = mk(1, 4, 0, 32'h35, 2, 0, 0, 1, 0, 1, 32'h35, 9, 32'h10, 32'hDEAD);
    tab[6] = mk(1, 2, 0, 32'h36, 6, 0, 32'hBEEF, 1, 9, 0, 32'h36, 6, 32'h10, 32'hDEAD);
    tab[7] = mk(0, 0, 0, 32'h37, 1, 0, 0, 0, 9, 0, 32'h37, 6, 32'h10, 32'hDEAD);
    tab[8] = mk(1, 0, 1, 32'h38, 8, 2, 32'hCAFE, 1, 32'hDEAD, 0, 32'h38, 8, 32'h12, 32'hCAFE);
    tab[9] = mk(1, 3, 0, 32'h39, 8, 0, 0, 1, 32'h38, 0, 32'h39, 8, 32'h12, 32'hCAFE);
`endif

    // Directed vectors: one clock per entry
    for (int k = 0; k < ntab; k++) begin
      rd_req = tab[k].req; rd_addr = tab[k].addr; cap_stb = tab[k].stb; din = tab[k].d;
      tick();
      chk($sformatf("vec%0d_ack", k), {31'd0, rd_ack}, {31'd0, tab[k].ack});
      chk($sformatf("vec%0d_data", k), rd_data, tab[k].rdata);
      chk($sformatf("vec%0d_err", k), {31'd0, rd_err}, {31'd0, tab[k].err});
      for (int i = 0; i < NCH; i++)
        chk($sformatf("vec%0d_ch%0d", k, i), data_out[i*DW +: DW], tab[k].q[i]);
    end

    // Randomized run against the reference model
    rst_reg = 1; rd_req = 0; cap_stb = 0;
    model_step();
    tick();
    for (int c = 0; c < 600; c++) begin
      rst_reg = ($urandom_range(0, 49) == 0);
      rd_req  = ($urandom_range(0, 1) == 1);
      rd_addr = 3'($urandom_range(0, 5));
      cap_stb = 4'($urandom_range(0, 15));
      for (int i = 0; i < NCH; i++)
        din[i] = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 1000));
      model_step();
      tick();
      chk($sformatf("rnd%0d_ack", c), {31'd0, rd_ack}, {31'd0, m_ack});
      chk($sformatf("rnd%0d_data", c), rd_data, m_data);
      chk($sformatf("rnd%0d_err", c), {31'd0, rd_err}, {31'd0, m_err});
      for (int i = 0; i < NCH; i++)
        chk($sformatf("rnd%0d_ch%0d", c, i), data_out[i*DW +: DW], m_reg[i]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ro_reg_bank.md
# ro_reg_bank

Parametrised bank of `CH_NUM` read-only status registers that hardware writes and software only reads. Each channel has a compile-time update mode:
- live sample
- capture on strobe
- sticky-OR with clear-on-read
- high-watermark with clear-on-read

A registered request/acknowledge read port with one-cycle latency sits between the status sources and the register-bus decoder in the `cbb/reg` family.

## Interface
Parameters:
- `DATA_W`, 32, width of each channel register
- `CH_NUM`, 4, number of channels (1..256)
- `ADDR_W`, 2, read address width; must satisfy 2^`ADDR_W` ≥ `CH_NUM`
- `DEFAULT_VALUE`, {`DATA_W`{1'b0}}, reset value of every channel and shadow register
- `MODE_VEC`, all zeros, 2 bits per channel; channel i uses `MODE_VEC[2i+1:2i]`; encodings are in `ro_reg_pkg`

Ports:
- `clk_reg`  in  1  register clock
- `rst_reg`  in  1  reset, synchronous, active-high
- `data_in`  in  `CH_NUM*DATA_W`  status sources; channel i occupies `[i*DATA_W +: DATA_W]`
- `cap_stb`  in  `CH_NUM`  per-channel capture strobe; used only in CAPTURE mode
- `rd_req`  in  1  read request, single-cycle qualifier
- `rd_addr`  in  `ADDR_W`  channel index, sampled with `rd_req`
- `rd_ack`  out  1  read data valid
- `rd_data`  out  `DATA_W`  read data
- `rd_err`  out  1  address out of range, valid with `rd_ack`
- `data_out`  out  `CH_NUM*DATA_W`  current contents of all channel registers, same packing as `data_in`

## Operation
Channel register update each `clk_reg` edge, by mode:
- LIVE (0): reg ← `data_in`.
- CAPTURE (1): reg ← `data_in` when `cap_stb[i]`=1; otherwise hold.
- STICKY (2):
  - No clearing read: reg ← reg | `data_in`.
  - Clearing read: reg ← `data_in`, so bits set in that cycle are never lost.
- MAXW (3):
  - No clearing read: reg ← unsigned max(reg, `data_in`).
  - Clearing read: reg ← `data_in`.
  - Full `DATA_W`-bit compare; no wrap.

Read port:
- `rd_req`=1 is accepted every cycle; back-to-back reads are allowed; there is no busy state.
- In range (`rd_addr` < `CH_NUM`): `rd_data` ← register value before this edge's update, `rd_err`=0.
- Out of range: `rd_data`=0, `rd_err`=1, no side effects.
- Clear-on-read applies only to STICKY and MAXW channels, and only to the addressed channel.
- LIVE and CAPTURE reads have no side effects.

Reset:
- `rst_reg` dominates all other inputs, including a simultaneous `rd_req`.
- All registers and shadows ← `DEFAULT_VALUE`.
- `rd_ack`=0, `rd_data`=0, `rd_err`=0.
- A read accepted in the cycle reset is asserted produces no `rd_ack`.

## Timing
- `data_out` updates at the edge after input conditions; LIVE shows one cycle of latency from `data_in`.
- `rd_ack` is asserted exactly one cycle after `rd_req` and lasts one cycle.
- `rd_data` and `rd_err` are registered and hold until the next accepted read.
- A clear takes effect at the same edge that latches `rd_data`; `data_out` shows the cleared/new value one cycle after `rd_req`.
- No combinational path from any input to any output.

## Configuration
Macro `RO_REG_BANK_SNAPSHOT_EN`.

Defined:
- A read of address 0 copies every channel register (pre-update value) into per-channel shadow registers at the same edge.
- Reads of addresses 1..`CH_NUM`-1 return the shadow value.
- Clear-on-read for STICKY/MAXW channels ≥1 occurs at snapshot time, i.e. on the address-0 read, not on their own read.
- Address 0 behaves as non-snapshot.
- Gives software an atomic multi-channel view.

Undefined:
- No shadow registers.
- Every address reads the live register and clears per address.

## Structure
- `ro_reg_pkg` holds:
  - mode localparams `RO_MODE_LIVE`/`CAPTURE`/`STICKY`/`MAXW` = 2'd0..3
  - `RO_MODE_W` = 2
- Sub-module `ro_reg_chan` implements one channel (mode mux, clear input, register).
- `ro_reg_bank` instantiates `ro_reg_chan` in a generate loop and owns the read port and shadow logic.

## Test plan
- Reset with `DEFAULT_VALUE`=32'hA5A5_0000 → all `data_out` channels = 32'hA5A5_0000; `rd_ack`/`rd_data`/`rd_err` = 0.
- STICKY channel 1:
  - Stimulus: `data_in` 32'h1, then 32'h4, then read ch1 while `data_in`=32'h10.
  - Required: `rd_data`=32'h5 one cycle later; `data_out` ch1 = 32'h10.
- MAXW channel 2:
  - Stimulus: 7, 3, 9, 2; then read.
  - Required: `rd_data`=9; afterwards reg = current `data_in`.
- CAPTURE channel 0: `cap_stb` pulsed with `data_in`=32'hDEAD → held at 32'hDEAD while `data_in` changes freely.
- `rd_addr`=`CH_NUM` → `rd_ack`=1, `rd_err`=1, `rd_data`=0; no channel cleared.
- With `RO_REG_BANK_SNAPSHOT_EN` defined:
  - Stimulus: read addr 0, change ch3 (LIVE), then read addr 3.
  - Required: addr-3 read returns the value ch3 had at the addr-0 read.
